// File: rtl/i_cache_fill_ctrl.sv
// Miss/fill sequencer for the fully associative I-cache: one line fill per miss,
// victim selection (first invalid way, else round-robin) and whole-cache flush.
module i_cache_fill_ctrl #(
  parameter int WAYS_NUM          = 16,
  parameter int CL_WIDTH          = 128,
  parameter int TAG_ADDRESS_WIDTH = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         miss_valid,
  input  logic [31:0]                  miss_address,
  input  logic                         flush,
  input  logic [WAYS_NUM-1:0]          way_valid_vec,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [31:0]                  mem_req_address,
  input  logic                         mem_rsp_valid,
  input  logic [31:0]                  mem_rsp_address,
  input  logic [CL_WIDTH-1:0]          mem_rsp_data,
  output logic                         fill_we,
  output logic [$clog2(WAYS_NUM)-1:0]  fill_way,
  output logic [TAG_ADDRESS_WIDTH-1:0] fill_tag,
  output logic [CL_WIDTH-1:0]          fill_data,
  output logic                         inv_all,
  output logic                         fill_done,
  output logic                         busy
);
  localparam int WAY_W = $clog2(WAYS_NUM);
  localparam int OFF_W = 32 - TAG_ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    FILL     = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  state_t                state_r, state_n;
  logic [31:0]           line_addr_r;
  logic [CL_WIDTH-1:0]   data_r;
  logic [WAY_W-1:0]      rr_ptr_r;
  logic                  flush_pending_r;
  logic                  guard_valid_r;
  logic                  req_valid_r, fill_we_r, inv_all_r, busy_r;
  logic                  accept_s, rsp_match_s, guard_hit_s, any_inv_s;
  logic [WAY_W-1:0]      victim_s;
  logic                  unused_s;

  assign unused_s    = ^{miss_address[OFF_W-1:0], mem_rsp_address[OFF_W-1:0]};
  assign rsp_match_s = mem_rsp_valid && (mem_rsp_address[31:OFF_W] == line_addr_r[31:OFF_W]);
  // The miss seen right after a fill was registered before the array write landed.
  assign guard_hit_s = guard_valid_r && (miss_address[31:OFF_W] == line_addr_r[31:OFF_W]);

  // Victim: lowest-index invalid way, falling back to the round-robin pointer.
  always_comb begin
    victim_s  = rr_ptr_r;
    any_inv_s = 1'b0;
    for (int i = WAYS_NUM - 1; i >= 0; i--) begin
      if (!way_valid_vec[i]) begin
        victim_s  = WAY_W'(i);
        any_inv_s = 1'b1;
      end else begin
        any_inv_s = any_inv_s;
      end
    end
  end

  // Next-state decode; flush takes priority over a miss in IDLE.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush || flush_pending_r) begin
          state_n = FLUSH;
        end else if (miss_valid && !guard_hit_s) begin
          state_n  = REQ;
          accept_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      REQ: begin
        if (mem_req_ready) state_n = WAIT_RSP;
        else               state_n = REQ;
      end
      WAIT_RSP: begin
        if (rsp_match_s) state_n = FILL;
        else             state_n = WAIT_RSP;
      end
      FILL: begin
        if (flush_pending_r || flush) state_n = FLUSH;
        else                          state_n = IDLE;
      end
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      line_addr_r     <= 32'h0000_0000;
      data_r          <= '0;
      rr_ptr_r        <= '0;
      flush_pending_r <= 1'b0;
      guard_valid_r   <= 1'b0;
      req_valid_r     <= 1'b0;
      fill_we_r       <= 1'b0;
      inv_all_r       <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r       <= state_n;
      guard_valid_r <= (state_r == FILL) && (state_n == IDLE);
      req_valid_r   <= (state_n == REQ);
      fill_we_r     <= (state_n == FILL);
      inv_all_r     <= (state_n == FLUSH);
      busy_r        <= (state_n != IDLE);
      if (accept_s) begin
        line_addr_r <= {miss_address[31:OFF_W], {OFF_W{1'b0}}};
      end
      if ((state_r == WAIT_RSP) && rsp_match_s) begin
        data_r <= mem_rsp_data;
      end
      if (state_r == FLUSH) begin
        flush_pending_r <= 1'b0;
      end else if (flush && ((state_r == REQ) || (state_r == WAIT_RSP) || (state_r == FILL))) begin
        flush_pending_r <= 1'b1;
      end
      if (state_r == FLUSH) begin
        rr_ptr_r <= '0;
      end else if ((state_r == FILL) && !any_inv_s) begin
        rr_ptr_r <= rr_ptr_r + WAY_W'(1);
      end
    end
  end

  assign mem_req_valid   = req_valid_r;
  assign mem_req_address = line_addr_r;
  assign fill_we         = fill_we_r;
  assign fill_done       = fill_we_r;
  assign fill_way        = fill_we_r ? victim_s : {WAY_W{1'b0}};
  assign fill_tag        = line_addr_r[31:OFF_W];
  assign fill_data       = data_r;
  assign inv_all         = inv_all_r;
  assign busy            = busy_r;
endmodule

// File: tb/tb_i_cache_fill_ctrl.sv
// Directed bench for i_cache_fill_ctrl; expected fills are queued when the
// response is driven and popped when fill_we appears.
module tb_i_cache_fill_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_valid;
  logic [31:0]  miss_address;
  logic         flush;
  logic [15:0]  way_valid_vec;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_address;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_address;
  logic [127:0] mem_rsp_data;
  logic         fill_we;
  logic [3:0]   fill_way;
  logic [27:0]  fill_tag;
  logic [127:0] fill_data;
  logic         inv_all;
  logic         fill_done;
  logic         busy;

  typedef struct packed {
    logic [3:0]   way;
    logic [27:0]  tag;
    logic [127:0] data;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  int         fill_cnt = 0;
  logic [3:0] model_rr = 4'd0;

  i_cache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_address(miss_address),
    .flush(flush), .way_valid_vec(way_valid_vec), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_address(mem_req_address),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_address(mem_rsp_address),
    .mem_rsp_data(mem_rsp_data), .fill_we(fill_we), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_data(fill_data), .inv_all(inv_all),
    .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_we === 1'b1) fill_cnt <= fill_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, mem_req_valid, 0);
    chk({tag, "_req_addr"}, mem_req_address, 0);
    chk({tag, "_fill_we"}, fill_we, 0);
    chk({tag, "_fill_way"}, fill_way, 0);
    chk({tag, "_fill_tag"}, fill_tag, 0);
    chk({tag, "_fill_data"}, fill_data, 0);
    chk({tag, "_inv_all"}, inv_all, 0);
    chk({tag, "_fill_done"}, fill_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Reference victim choice for the current way_valid_vec.
  task automatic model_way(output logic [3:0] w);
    if (way_valid_vec != 16'hFFFF) begin
      w = 4'd0;
      for (int i = 15; i >= 0; i--) if (!way_valid_vec[i]) w = 4'(i);
    end else begin
      w = model_rr;
      model_rr = model_rr + 4'd1;
    end
  endtask

  // Present a miss, check the request, hold ready low for 'hold' cycles, then grant.
  task automatic miss_to_wait(input logic [31:0] a, input int hold);
    logic [31:0] line;
    line = {a[31:4], 4'h0};
    miss_valid = 1'b1; miss_address = a;
    step;
    miss_valid = 1'b0;
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_address, line);
    for (int i = 0; i < hold; i++) begin
      step;
      chk("hold_valid", mem_req_valid, 1);
      chk("hold_addr", mem_req_address, line);
    end
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
    chk("wait_busy", busy, 1);
    chk("wait_req_drop", mem_req_valid, 0);
  endtask

  // Drive the matching response; returns in the FILL cycle.
  task automatic respond(input logic [31:0] a, input logic [127:0] d);
    logic [3:0] w;
    exp_t       e;
    int         n;
    model_way(w);
    sb_q.push_back('{way: w, tag: a[31:4], data: d});
    mem_rsp_valid = 1'b1; mem_rsp_address = a; mem_rsp_data = d;
    step;
    mem_rsp_valid = 1'b0;
    n = 0;
    while (fill_we !== 1'b1 && n < 8) begin
      step;
      n++;
    end
    chk("fill_latency", n, 0);
    if (fill_we === 1'b1) begin
      e = sb_q.pop_front();
      chk("fill_way", fill_way, e.way);
      chk("fill_tag", fill_tag, e.tag);
      chk("fill_data", fill_data, e.data);
      chk("fill_done", fill_done, 1);
    end else begin
      chk("fill_timeout", fill_we, 1);
    end
  endtask

  task automatic finish_fill;
    step;
    chk("post_fill_busy", busy, 0);
    chk("post_fill_we", fill_we, 0);
    step;
  endtask

  initial begin
    int          cnt0;
    logic [31:0] a;
    rst_n = 1'b0; miss_valid = 1'b0; miss_address = 32'h0; flush = 1'b0;
    way_valid_vec = 16'h0000; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_address = 32'h0; mem_rsp_data = 128'h0;
    #1;
    chk_all_zero("reset");
    step; step;
    rst_n = 1'b1;
    step;

    // Basic miss, zero-wait handshake.
    cnt0 = fill_cnt;
    miss_to_wait(32'h0000_1234, 0);
    respond(32'h0000_1230, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    finish_fill;
    chk("one_fill_done", fill_cnt - cnt0, 1);

    // Backpressure plus a stray response to another line.
    way_valid_vec = 16'h0001;
    miss_to_wait(32'h0000_1234, 5);
    mem_rsp_valid = 1'b1; mem_rsp_address = 32'h0000_5550; mem_rsp_data = 128'hdead;
    step;
    mem_rsp_valid = 1'b0;
    chk("stray_no_fill", fill_we, 0);
    chk("stray_busy", busy, 1);
    respond(32'h0000_1230, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    finish_fill;

    // Round-robin over all-valid ways, 17 fills to cover the wrap.
    way_valid_vec = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      a = 32'h0001_0000 + 32'(i * 16);
      miss_to_wait(a, 0);
      respond(a, {$urandom, $urandom, $urandom, $urandom});
      finish_fill;
    end

    // Flush during WAIT_RSP: fill completes, then inv_all, rr back to 0.
    miss_to_wait(32'h0000_7770, 0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_wait_no_inv", inv_all, 0);
    respond(32'h0000_7770, 128'habcd);
    step;
    chk("flush_after_fill_inv", inv_all, 1);
    chk("flush_after_fill_busy", busy, 1);
    chk("flush_after_fill_we", fill_we, 0);
    step;
    chk("flush_done_inv", inv_all, 0);
    chk("flush_done_busy", busy, 0);
    model_rr = 4'd0;
    miss_to_wait(32'h0000_8880, 0);
    respond(32'h0000_8880, 128'h8888);
    finish_fill;

    // Flush and miss in the same IDLE cycle.
    flush = 1'b1; miss_valid = 1'b1; miss_address = 32'h0000_9990;
    step;
    flush = 1'b0; miss_valid = 1'b0;
    chk("fm_inv", inv_all, 1);
    chk("fm_no_req", mem_req_valid, 0);
    step;
    chk("fm_inv_clear", inv_all, 0);
    chk("fm_busy", busy, 0);
    chk("fm_miss_dropped", mem_req_valid, 0);
    model_rr = 4'd0;
    step;

    // Guard: same-line miss right after FILL is dropped.
    miss_to_wait(32'h0000_2000, 0);
    respond(32'h0000_2000, 128'h2000);
    step;
    miss_valid = 1'b1; miss_address = 32'h0000_2008;
    step;
    miss_valid = 1'b0;
    chk("guard_drop_req", mem_req_valid, 0);
    chk("guard_drop_busy", busy, 0);
    step;

    // Guard: different-line miss in the same cycle is accepted.
    miss_to_wait(32'h0000_3000, 0);
    respond(32'h0000_3000, 128'h3000);
    step;
    miss_to_wait(32'h0000_4004, 0);
    respond(32'h0000_4000, 128'h4000);
    finish_fill;

    // Asynchronous reset in WAIT_RSP; late response ignored.
    miss_to_wait(32'h0000_6000, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_rr = 4'd0;
    cnt0 = fill_cnt;
    step;
    rst_n = 1'b1;
    step;
    mem_rsp_valid = 1'b1; mem_rsp_address = 32'h0000_6000; mem_rsp_data = 128'h6000;
    step;
    mem_rsp_valid = 1'b0;
    chk("late_rsp_no_fill", fill_we, 0);
    chk("late_rsp_busy", busy, 0);
    step; step;
    chk("late_rsp_fill_cnt", fill_cnt - cnt0, 0);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
